// File: rtl/tmr_test_pkg.sv
// Shared types and helpers for the TMR fault-injection test block.
// The injector FSM states and the counter saturation helper live here.
package tmr_test_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INJECT = 2'd1,
      DONE   = 2'd2
   } inj_state_e;

   // True when the low w bits of v are all ones (counter at its ceiling).
   function automatic logic at_max(input logic [31:0] v, input int w);
      return v == (32'hFFFF_FFFF >> (32 - w));
   endfunction

endpackage

// File: rtl/tmr_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module tmr_sat_counter
   import tmr_test_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && !at_max(32'(cnt_q), CNT_W))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/tmr_fault_injector.sv
// Replicates source data onto an M*N voter bus, flips one bit of one replica on
// command for a set number of cycles, and scores whether the voter warned.
//
// state  | meaning
// IDLE   | clean replication, waiting for a legal injection request
// INJECT | one mask bit set, faulty replica on rep_o, sampling warn_i
// DONE   | one-cycle wrap-up, bumps detected or missed counter
module tmr_fault_injector
   import tmr_test_pkg::*;
#(
   parameter int M      = 3,
   parameter int N      = 4,
   parameter int HOLD_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         data_i,
   output logic [M*N-1:0]       rep_o,
   input  logic                 inj_start_i,
   input  logic [$clog2(M)-1:0] inj_replica_i,
   input  logic [$clog2(N)-1:0] inj_bit_i,
   input  logic [HOLD_W-1:0]    inj_hold_i,
   output logic                 inj_busy_o,
   output logic                 inj_done_o,
   input  logic                 warn_i,
   input  logic [N-1:0]         voted_i,
   output logic                 mismatch_o,
   input  logic                 cnt_clr_i,
   output logic [CNT_W-1:0]     det_cnt_o,
   output logic [CNT_W-1:0]     miss_cnt_o
);

   localparam int MW = M * N;
   localparam logic [MW-1:0] ONE = MW'(1);

   inj_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [MW-1:0]     mask_q, mask_d;
   logic              seen_q, seen_d;
   logic [MW-1:0]     rep_q;
   logic [N-1:0]      clean_q;
   logic              mismatch_q;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      mask_d  = mask_q;
      seen_d  = seen_q;
      unique case (state_q)
         IDLE: begin
            if (inj_start_i && int'(inj_replica_i) < M && int'(inj_bit_i) < N) begin
               state_d = INJECT;
               hold_d  = (inj_hold_i == '0) ? HOLD_W'(1) : inj_hold_i;
               mask_d  = ONE << (int'(inj_replica_i) * N + int'(inj_bit_i));
               seen_d  = 1'b0;
            end
         end
         INJECT: begin
            seen_d = seen_q | warn_i;
            if (hold_q <= HOLD_W'(1)) begin
               mask_d  = '0;
               state_d = DONE;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // rep uses the next mask so the fault lands the cycle after acceptance.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         mask_q     <= '0;
         seen_q     <= 1'b0;
         rep_q      <= '0;
         clean_q    <= '0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         mask_q     <= mask_d;
         seen_q     <= seen_d;
         rep_q      <= {M{data_i}} ^ mask_d;
         clean_q    <= data_i;
         mismatch_q <= (voted_i != clean_q);
      end
   end

   tmr_sat_counter #(.CNT_W(CNT_W)) u_det_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i ((state_q == DONE) && seen_q),
      .clr_i (cnt_clr_i),
      .cnt_o (det_cnt_o)
   );

   tmr_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i ((state_q == DONE) && !seen_q),
      .clr_i (cnt_clr_i),
      .cnt_o (miss_cnt_o)
   );

   assign rep_o      = rep_q;
   assign inj_busy_o = (state_q != IDLE);
   assign inj_done_o = (state_q == DONE);
   assign mismatch_o = mismatch_q;

endmodule

// File: tb/tb_tmr_fault_injector.sv
// Scoreboard bench: the driver models each edge from injection windows and
// pushes expectations; a negedge monitor pops and compares them.
module tb_tmr_fault_injector;

   localparam int M = 3, N = 4, HOLD_W = 8, CNT_W = 2;
   localparam int MW = M * N;
   localparam int RW = $clog2(M), BW = $clog2(N);
   localparam int MAXC = (1 << CNT_W) - 1;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [N-1:0]      data_i;
   logic [MW-1:0]     rep_o;
   logic              inj_start_i;
   logic [RW-1:0]     inj_replica_i;
   logic [BW-1:0]     inj_bit_i;
   logic [HOLD_W-1:0] inj_hold_i;
   logic              inj_busy_o, inj_done_o;
   logic              warn_i;
   logic [N-1:0]      voted_i;
   logic              mismatch_o;
   logic              cnt_clr_i;
   logic [CNT_W-1:0]  det_cnt_o, miss_cnt_o;

   always #5 clk_i = ~clk_i;

   tmr_fault_injector #(.M(M), .N(N), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .rep_o(rep_o),
      .inj_start_i(inj_start_i), .inj_replica_i(inj_replica_i),
      .inj_bit_i(inj_bit_i), .inj_hold_i(inj_hold_i),
      .inj_busy_o(inj_busy_o), .inj_done_o(inj_done_o),
      .warn_i(warn_i), .voted_i(voted_i), .mismatch_o(mismatch_o),
      .cnt_clr_i(cnt_clr_i), .det_cnt_o(det_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   typedef struct {
      int               e;
      logic [MW-1:0]    rep;
      logic             busy, done, mism;
      logic [CNT_W-1:0] det, miss;
   } exp_t;

   exp_t q[$];
   int   ecnt = 0;
   int   total_cnt = 0, pass_cnt = 0;

   always @(posedge clk_i) ecnt <= ecnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s at edge %0d: got %0h expected %0h", nm, ecnt, act, req);
   endtask

   initial forever begin
      exp_t x;
      @(negedge clk_i);
      while (q.size() > 0 && q[0].e <= ecnt) begin
         x = q.pop_front();
         if (x.e != ecnt) chk("edge_tag", ecnt, x.e);
         chk("rep_o", 32'(rep_o), 32'(x.rep));
         chk("busy", 32'(inj_busy_o), 32'(x.busy));
         chk("done", 32'(inj_done_o), 32'(x.done));
         chk("mismatch", 32'(mismatch_o), 32'(x.mism));
         chk("det_cnt", 32'(det_cnt_o), 32'(x.det));
         chk("miss_cnt", 32'(miss_cnt_o), 32'(x.miss));
      end
   end

   // Reference model: one active window per accepted request.
   bit           m_act;
   int           m_k, m_h, m_pos, m_det, m_miss;
   bit           m_seen;
   logic [N-1:0] m_prev;

   task automatic model_reset();
      m_act = 0; m_seen = 0; m_det = 0; m_miss = 0; m_prev = '0;
   endtask

   // Called at posedge+1: drives inputs for the next edge, then waits it out.
   task automatic drive(input logic [N-1:0] d, input bit st, input int rp, input int bt,
                        input int hd, input bit clr, input bit wen, input bit corrupt);
      int            e, ones;
      bit            idle, w;
      logic [N-1:0]  maj;
      logic [MW-1:0] frep;
      exp_t          x;
      e = ecnt + 1;
      maj = '0;
      for (int b = 0; b < N; b++) begin
         ones = 0;
         for (int r = 0; r < M; r++) ones += int'(rep_o[r*N + b]);
         maj[b] = (ones > M / 2);
      end
      w = 0;
      for (int r = 0; r < M; r++) if (rep_o[r*N +: N] != maj) w = 1;
      data_i        = d;
      inj_start_i   = st;
      inj_replica_i = RW'(rp);
      inj_bit_i     = BW'(bt);
      inj_hold_i    = HOLD_W'(hd);
      cnt_clr_i     = clr;
      warn_i        = wen & w;
      voted_i       = corrupt ? (maj ^ N'(1)) : maj;

      idle = !m_act;
      if (m_act && e >= m_k + 1 && e <= m_k + m_h) m_seen = m_seen | warn_i;
      if (clr) begin
         m_det = 0; m_miss = 0;
      end else if (m_act && e == m_k + m_h + 1) begin
         if (m_seen) m_det = (m_det < MAXC) ? m_det + 1 : MAXC;
         else        m_miss = (m_miss < MAXC) ? m_miss + 1 : MAXC;
      end
      if (m_act && e == m_k + m_h + 1) m_act = 0;
      if (st && idle && rp < M && bt < N) begin
         m_act = 1; m_k = e; m_h = (hd == 0) ? 1 : hd; m_pos = rp * N + bt; m_seen = 0;
      end

      frep = {M{d}};
      if (m_act && e >= m_k && e <= m_k + m_h - 1) frep = frep ^ (MW'(1) << m_pos);
      x.e    = e;
      x.rep  = frep;
      x.busy = m_act && e <= m_k + m_h;
      x.done = m_act && e == m_k + m_h;
      x.mism = (voted_i != m_prev);
      x.det  = CNT_W'(m_det);
      x.miss = CNT_W'(m_miss);
      m_prev = d;
      q.push_back(x);
      @(posedge clk_i); #1;
   endtask

   task automatic idle_n(input int n, input logic [N-1:0] d, input bit wen);
      for (int i = 0; i < n; i++) drive(d, 0, 0, 0, 0, 0, wen, 0);
   endtask

   initial begin
      rst_i = 1'b1; data_i = '0; inj_start_i = 0; inj_replica_i = '0; inj_bit_i = '0;
      inj_hold_i = '0; warn_i = 0; voted_i = '0; cnt_clr_i = 0;
      model_reset();
      #12;
      chk("reset_rep", 32'(rep_o), 0);
      chk("reset_busy", 32'(inj_busy_o), 0);
      chk("reset_done", 32'(inj_done_o), 0);
      chk("reset_mismatch", 32'(mismatch_o), 0);
      chk("reset_det", 32'(det_cnt_o), 0);
      chk("reset_miss", 32'(miss_cnt_o), 0);
      @(posedge clk_i); #1 rst_i = 1'b0;

      idle_n(3, 4'hA, 1);

      drive(4'h0, 1, 1, 2, 3, 0, 1, 0);
      idle_n(5, 4'h0, 1);

      drive(4'h0, 1, 0, 0, 0, 0, 0, 0);
      idle_n(4, 4'h0, 0);

      drive(4'h5, 1, 3, 1, 2, 0, 1, 0);
      idle_n(2, 4'h5, 1);
      drive(4'h9, 1, 2, 1, 4, 0, 1, 0);
      drive(4'h9, 1, 0, 3, 2, 0, 1, 0);
      idle_n(8, 4'h9, 1);

      drive(4'h3, 1, 1, 0, 200, 0, 1, 0);
      for (int i = 0; i < 49; i++) drive(N'($urandom), 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk_i); #1 rst_i = 1'b1; #1;
      chk("midrst_rep", 32'(rep_o), 0);
      chk("midrst_busy", 32'(inj_busy_o), 0);
      chk("midrst_det", 32'(det_cnt_o), 0);
      chk("midrst_miss", 32'(miss_cnt_o), 0);
      model_reset();
      @(posedge clk_i); #1 rst_i = 1'b0;
      idle_n(3, 4'h6, 1);

      for (int i = 0; i < 5; i++) begin
         drive(N'($urandom), 1, $urandom_range(0, M - 1), $urandom_range(0, N - 1), 1, 0, 1, 0);
         for (int j = 0; j < 3; j++) drive(N'($urandom), 0, 0, 0, 0, 0, 1, 0);
      end

      drive(4'hC, 1, 2, 3, 2, 0, 1, 0);
      idle_n(2, 4'hC, 1);
      drive(4'hC, 0, 0, 0, 0, 1, 1, 0);
      idle_n(2, 4'hC, 1);

      for (int i = 0; i < 600; i++) begin
         drive(N'($urandom),
               ($urandom_range(0, 3) == 0),
               $urandom_range(0, 3),
               $urandom_range(0, N - 1),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 5),
               ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 15) == 0));
      end
      idle_n(2, 4'h0, 1);
      @(negedge clk_i); #1;
      chk("queue_drain", 32'(q.size()), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/tmr_fault_injector.md
Name: tmr_fault_injector

Overview:
- Drives the M*N replicated bus that feeds the multi-voter in the radiation-test firmware.
- Registers N-bit source data into M identical replicas.
- On command, flips one selected bit of one selected replica for a programmable number of cycles.
- Checks the voter's warn/voted outputs during and after each injection, and keeps saturating detected/missed counters so the test system can prove voter coverage.

Parameters:
- M, 3: number of replicas (M >= 3, odd)
- N, 4: width of one replica
- HOLD_W, 8: width of injection-duration field
- CNT_W, 16: width of statistics counters

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- data_i  in  N  source data to replicate
- rep_o  out  M*N  replicated bus; replica r occupies bits [r*N +: N]
- inj_start_i  in  1  injection request, single-cycle sample
- inj_replica_i  in  $clog2(M)  replica index to corrupt
- inj_bit_i  in  $clog2(N)  bit index within that replica
- inj_hold_i  in  HOLD_W  fault duration in cycles; 0 treated as 1
- inj_busy_o  out  1  injection sequence in progress
- inj_done_o  out  1  one-cycle pulse at sequence end
- warn_i  in  1  voter warning output
- voted_i  in  N  voter data output
- mismatch_o  out  1  registered: voted_i differed from clean reference
- cnt_clr_i  in  1  synchronous clear of counters
- det_cnt_o  out  CNT_W  injections where warn_i was seen
- miss_cnt_o  out  CNT_W  injections where warn_i was never seen

Behaviour:
- Reset values:
  - rep_o = 0, clean reference = 0, mask = 0.
  - inj_busy_o = 0, inj_done_o = 0, mismatch_o = 0.
  - Both counters = 0. FSM in IDLE.
- Datapath:
  - rep_r <= {M{data_i}} XOR mask_r every cycle; latency 1 cycle.
  - clean_r <= data_i in parallel.
  - mask_r is M*N wide with at most one bit set.
- FSM states: IDLE, INJECT, DONE.
- IDLE:
  - inj_start_i=1 with inj_replica_i<M and inj_bit_i<N:
    - latch indices;
    - hold_cnt = max(inj_hold_i,1);
    - set mask bit (inj_replica_i*N + inj_bit_i);
    - clear seen_warn;
    - go INJECT.
  - Out-of-range indices: request ignored; no state change, no counter change.
- INJECT:
  - inj_busy_o=1.
  - Faulty rep_o is visible for exactly hold_cnt consecutive cycles, starting the cycle after start is accepted.
  - In each of those cycles, warn_i=1 sets sticky seen_warn.
  - After the last faulty cycle, mask is cleared and FSM goes to DONE.
- DONE, one cycle:
  - inj_busy_o=1, inj_done_o=1.
  - det_cnt_o++ if seen_warn, else miss_cnt_o++.
  - Counters saturate at all-ones.
  - Return to IDLE.
- inj_start_i while busy: ignored (no queueing).
- cnt_clr_i:
  - zeroes both counters.
  - Same cycle as a DONE increment: clear wins, counter = 0.
- mismatch_o:
  - Registered compare (voted_i != clean_r), valid every cycle.
  - With one replica faulted and M>=3, mismatch_o must stay 0.
  - It is an independent voter-integrity check, not FSM-gated.
- Reset mid-INJECT: mask cleared immediately (asynchronously), rep_o = 0, no counter update, FSM IDLE.
- data_i changing during injection: fault mask XORs the current data each cycle; the flip follows the data.

Decomposition:
- Shared package tmr_test_pkg:
  - FSM state enum (IDLE, INJECT, DONE);
  - localparams REP_IDX_W=$clog2(M), BIT_IDX_W=$clog2(N);
  - a saturating-increment function.
- One natural sub-module, tmr_sat_counter (CNT_W, inc, clr, saturate); instantiated twice.
- Top block holds the FSM, mask/replication datapath and compare.

Test Plan:
- Idle replication, M=3, N=4, data_i=4'hA:
  - rep_o=12'hAAA one cycle later.
  - mismatch_o=0, busy=0, both counters 0.
- Single injection with correct voter in loop:
  - stimulus: data_i=4'h0, replica=1, bit=2, hold=3.
  - rep_o=12'h040 for exactly 3 cycles, then 12'h000.
  - warn_i high during those cycles; done pulses 1 cycle later; det_cnt_o=1, miss_cnt_o=0, mismatch_o=0 throughout.
- Missed detection: warn_i tied 0, replica=0, bit=0, hold=0:
  - 1 faulty cycle, rep_o=12'h001; done pulse; miss_cnt_o=1.
- Illegal/overlapping requests:
  - replica=3 -> ignored, busy stays 0.
  - second start during INJECT -> ignored; exactly one done pulse, one counter increment.
- Async reset asserted mid-INJECT (hold=200, reset at cycle 50):
  - rep_o=0 and busy=0 immediately; counters 0.
  - After release, rep_o=replicated data_i with no residual fault.
- Saturation and clear:
  - CNT_W=2, 5 detected injections -> det_cnt_o=3.
  - cnt_clr_i coincident with a DONE cycle -> det_cnt_o=0 next cycle.
